// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg: shared types, constants and address helpers for fetch_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [63:0] BASE_ADDR_DEF  = 64'h0000_0000_0004_0000;
  localparam int          IMEM_DEPTH_DEF = 101;
  localparam int          LINE_W_DEF     = 7;
  localparam logic [63:0] PC_INCR        = 64'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_HALT  = 3'd5
  } fetch_state_e;

  function automatic logic [63:0] line_of(input logic [63:0] pc,
                                          input logic [63:0] base);
    logic [63:0] off;
    off = pc - base;
    return off >> 2;
  endfunction

  // Lower bound is checked explicitly so a PC below base cannot alias into range.
  function automatic logic in_range(input logic [63:0] pc,
                                    input logic [63:0] base,
                                    input int          depth);
    logic [63:0] off;
    off = pc - base;
    return (pc >= base) && (pc[1:0] == 2'b00) && ((off >> 2) < 64'(depth));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_branch_resolve.sv
// ============================================================================
// branch_resolve: combinational BranchEqual/BranchNotEqual decision and target.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolve (
  input  logic        br_valid_i,
  input  logic        br_eq_i,
  input  logic        br_ne_i,
  input  logic        zero_flag_i,
  input  logic [63:0] br_pc_i,
  input  logic [63:0] immediate_i,
  output logic        taken_o,
  output logic [63:0] target_o
);

  assign taken_o  = br_valid_i & ((br_eq_i & zero_flag_i) | (br_ne_i & ~zero_flag_i));
  assign target_o = br_pc_i + immediate_i;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer: PC owner, imem req/ack fetch and branch redirect controller.
// Optional FETCH_PERF_CNT_EN adds fetched/flushed performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int          LINE_W     = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_o,
  output logic [LINE_W-1:0] imem_line_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_out_o,
  output logic [63:0]       instr_pc_o,
  input  logic              br_valid_i,
  input  logic              br_eq_i,
  input  logic              br_ne_i,
  input  logic              zero_flag_i,
  input  logic [63:0]       br_pc_i,
  input  logic [63:0]       immediate_i,
  output logic              fetch_fault_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_flushed_o
`endif
);

  fetch_state_e      state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic              req_q, req_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0]       instr_q, instr_d;
  logic [63:0]       ipc_q, ipc_d;

  logic              w_taken;
  logic [63:0]       w_target;
  logic              w_pc_ok;
  logic              w_xfer;

  branch_resolve u_branch_resolve (
    .br_valid_i  (br_valid_i),
    .br_eq_i     (br_eq_i),
    .br_ne_i     (br_ne_i),
    .zero_flag_i (zero_flag_i),
    .br_pc_i     (br_pc_i),
    .immediate_i (immediate_i),
    .taken_o     (w_taken),
    .target_o    (w_target)
  );

  assign w_pc_ok = in_range(pc_q, BASE_ADDR, IMEM_DEPTH);
  assign w_xfer  = instr_valid_o & instr_ready_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    line_d  = line_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (w_pc_ok) begin
          req_d   = 1'b1;
          line_d  = LINE_W'(line_of(pc_q, BASE_ADDR));
          state_d = S_WAIT;
        end else begin
          state_d = S_HALT;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          instr_d = imem_rdata_i;
          ipc_d   = pc_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready_i) begin
          pc_d    = pc_q + PC_INCR;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // A taken redirect overrides the sequential result; an outstanding
    // request must still complete, so WAIT without ack parks in DRAIN.
    if (w_taken) begin
      pc_d = w_target;
      unique case (state_q)
        S_WAIT: begin
          instr_d = instr_q;
          ipc_d   = ipc_q;
          state_d = imem_ack_i ? S_REQ : S_DRAIN;
        end
        S_DRAIN: begin
        end
        default: begin
          req_d   = 1'b0;
          line_d  = line_q;
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= BASE_ADDR;
      req_q   <= 1'b0;
      line_q  <= '0;
      instr_q <= '0;
      ipc_q   <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      line_q  <= line_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_line_o   = line_q;
  assign instr_valid_o = (state_q == S_HOLD);
  assign instr_out_o   = instr_q;
  assign instr_pc_o    = ipc_q;
  assign fetch_fault_o = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, flushed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (w_xfer)  fetched_q <= fetched_q + 32'd1;
      if (w_taken) flushed_q <= flushed_q + 32'd1;
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_flushed_o = flushed_q;
`else
  logic w_unused;
  assign w_unused = w_xfer;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer: directed stimulus with a transfer scoreboard and monitor.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0004_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [6:0]  imem_line;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [63:0] instr_pc;
  logic        br_valid = 1'b0;
  logic        br_eq = 1'b0;
  logic        br_ne = 1'b0;
  logic        zero_flag = 1'b0;
  logic [63:0] br_pc = '0;
  logic [63:0] immediate = '0;
  logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  xfer_t sb_q[$];
  int    exp_line_q[$];
  int    checks = 0;
  int    passes = 0;
  int    mem_lat = 1;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req),
    .imem_line_o   (imem_line),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_out_o   (instr_out),
    .instr_pc_o    (instr_pc),
    .br_valid_i    (br_valid),
    .br_eq_i       (br_eq),
    .br_ne_i       (br_ne),
    .zero_flag_i   (zero_flag),
    .br_pc_i       (br_pc),
    .immediate_i   (immediate),
    .fetch_fault_o (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o(perf_fetched),
    .perf_flushed_o(perf_flushed)
`endif
  );

  function automatic logic [31:0] mem_word(input int line);
    return 32'hC0DE_0000 | 32'(line);
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_xfer(input logic [63:0] pc, input int line);
    xfer_t e;
    e.pc    = pc;
    e.instr = mem_word(line);
    sb_q.push_back(e);
  endtask

  // Instruction memory: acks after mem_lat cycles of a held request.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !imem_req) begin
        cnt      = 0;
        imem_ack = 1'b0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(int'(imem_line));
          if (exp_line_q.size() > 0) begin
            int el;
            el = exp_line_q.pop_front();
            check64("imem_line", 64'(imem_line), 64'(el));
          end
        end else begin
          imem_ack = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every decode handshake must match the queue head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_xfer: got pc %h instr %h, none expected", instr_pc, instr_out);
      end else begin
        xfer_t e;
        e = sb_q.pop_front();
        check64("xfer_pc", instr_pc, e.pc);
        check64("xfer_instr", 64'(instr_out), 64'(e.instr));
      end
    end
  end

  task automatic wait_empty(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) return;
    end
    checks++;
    $display("FAIL wait_empty: got %0d pending transfers, required 0", sb_q.size());
    sb_q.delete();
  endtask

  task automatic wait_sig(input string name, input int which, input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (which == 0 && imem_req) return;
      if (which == 1 && instr_valid) return;
    end
    checks++;
    $display("FAIL %s: got timeout after %0d cycles, required assertion", name, max);
  endtask

  task automatic check_reset_outputs();
    check64("rst_imem_req", 64'(imem_req), 64'd0);
    check64("rst_imem_line", 64'(imem_line), 64'd0);
    check64("rst_instr_valid", 64'(instr_valid), 64'd0);
    check64("rst_instr_out", 64'(instr_out), 64'd0);
    check64("rst_instr_pc", instr_pc, BASE);
    check64("rst_fetch_fault", 64'(fetch_fault), 64'd0);
  endtask

  task automatic drive_br(input logic eq, input logic ne, input logic z,
                          input logic [63:0] pc, input logic [63:0] imm);
    br_valid  = 1'b1;
    br_eq     = eq;
    br_ne     = ne;
    zero_flag = z;
    br_pc     = pc;
    immediate = imm;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs();
    check64("rst_state", 64'(dut.state_q), 64'(S_IDLE));

    // Sequential fetch, ready high, 1-cycle ack
    push_xfer(BASE,        0);
    push_xfer(BASE + 4,    1);
    push_xfer(BASE + 8,    2);
    exp_line_q.push_back(0);
    exp_line_q.push_back(1);
    exp_line_q.push_back(2);
    instr_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_empty(60);
    instr_ready = 1'b0;

    // Backpressure in HOLD for 5 cycles
    wait_sig("wait_valid_hold", 1, 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64("hold_instr_out", 64'(instr_out), 64'(mem_word(3)));
      check64("hold_instr_pc", instr_pc, BASE + 12);
      check64("hold_imem_req", 64'(imem_req), 64'd0);
      check64("hold_valid", 64'(instr_valid), 64'd1);
    end
    mem_lat = 3;
    push_xfer(BASE + 12, 3);
    instr_ready = 1'b1;
    wait_empty(20);
    instr_ready = 1'b0;

    // Taken BranchEqual during WAIT with 3-cycle ack: drain then refetch 0x40000
    wait_sig("wait_req_drain", 0, 20);
    drive_br(1'b1, 1'b0, 1'b1, BASE + 8, -64'sd8);
    @(posedge clk);
    #1 br_valid = 1'b0;
    @(negedge clk);
    check64("drain_state", 64'(dut.state_q), 64'(S_DRAIN));
    check64("drain_req", 64'(imem_req), 64'd1);
    check64("drain_valid", 64'(instr_valid), 64'd0);
    push_xfer(BASE, 0);
    instr_ready = 1'b1;
    wait_empty(40);
    instr_ready = 1'b0;

    // BranchNotEqual with zero set: not taken
    mem_lat = 1;
    wait_sig("wait_valid_ne", 1, 30);
    drive_br(1'b0, 1'b1, 1'b1, BASE, 64'h100);
    @(posedge clk);
    #1 br_valid = 1'b0;
    @(negedge clk);
    check64("ne_state", 64'(dut.state_q), 64'(S_HOLD));
    check64("ne_instr_pc", instr_pc, BASE + 4);
    push_xfer(BASE + 4, 1);
    push_xfer(BASE + 8, 2);
    instr_ready = 1'b1;
    wait_empty(30);
    instr_ready = 1'b0;

    // Misaligned target halts; a later taken redirect recovers at line 0
    wait_sig("wait_valid_fault", 1, 20);
    drive_br(1'b1, 1'b0, 1'b1, BASE, 64'd2);
    @(posedge clk);
    #1 br_valid = 1'b0;
    @(negedge clk);
    check64("redir_valid_drop", 64'(instr_valid), 64'd0);
    @(negedge clk);
    check64("halt_fault", 64'(fetch_fault), 64'd1);
    check64("halt_req", 64'(imem_req), 64'd0);
    check64("halt_valid", 64'(instr_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check64("halt_stays", 64'(fetch_fault), 64'd1);
    end
    @(posedge clk);
    #1;
    drive_br(1'b0, 1'b1, 1'b0, BASE, 64'd0);
    exp_line_q.push_back(0);
    push_xfer(BASE, 0);
    instr_ready = 1'b1;
    @(posedge clk);
    #1 br_valid = 1'b0;
    @(negedge clk);
    check64("fault_cleared", 64'(fetch_fault), 64'd0);
    wait_empty(20);
    instr_ready = 1'b0;

    // Asynchronous reset during WAIT
    mem_lat = 3;
    wait_sig("wait_req_reset", 0, 20);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    mem_lat = 1;
    exp_line_q.push_back(0);
    push_xfer(BASE, 0);
    instr_ready = 1'b1;
    wait_empty(20);
    instr_ready = 1'b0;
    repeat (4) @(posedge clk);
    if (exp_line_q.size() != 0) begin
      checks++;
      $display("FAIL line_queue: got %0d pending lines, required 0", exp_line_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
